// File: rtl/craps_table_scheduler.sv
// Shares one dice-game controller among four players: round-robin turn grants,
// idle-turn forfeit, per-player saturating win counters and a sticky protocol-error flag.
module craps_table_scheduler #(
  parameter int TIMEOUT = 200,
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic               win,
  input  logic               lose,
  input  logic [1:0]         score_sel,
  output logic               roll,
  output logic               game_rst,
  output logic [3:0]         grant,
  output logic               turn_done,
  output logic [SCORE_W-1:0] score,
  output logic               err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    RELEASE,
    SETTLE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         grant_q, grant_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               win_inc;
  logic               own_req;
  logic               found;
  logic [1:0]         pick;
  logic [1:0]         idx;
  logic [SCORE_W-1:0] score_arr [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Round-robin search starting one past the previous owner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign own_req = |(req & grant_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    win_inc   = 1'b0;
    roll      = 1'b0;
    game_rst  = reset;
    turn_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (win || lose) err_d = 1'b1;
        if (found) begin
          grant_d = 4'(1) << pick;
          owner_d = pick;
          cnt_d   = '0;
          state_d = TURN;
        end
      end
      TURN: begin
        roll = own_req && !reset;
        if (lose) begin
          if (win) err_d = 1'b1;
          state_d = RELEASE;
        end else if (win) begin
          win_inc = 1'b1;
          state_d = RELEASE;
        end else if (own_req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Forfeit: reset the game controller and close the turn without scoring.
          game_rst = 1'b1;
          grant_d  = '0;
          state_d  = SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!win && !lose) begin
          grant_d = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        turn_done = !reset;
        last_d    = owner_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_score
      logic [SCORE_W-1:0] pl_score_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          pl_score_q <= '0;
        end else if (win_inc && grant_q[gi] && (pl_score_q != {SCORE_W{1'b1}})) begin
          pl_score_q <= pl_score_q + 1'b1;
        end
      end
      assign score_arr[gi] = pl_score_q;
    end
  endgenerate

  assign score = score_arr[score_sel];
  assign grant = grant_q;
  assign err   = err_q;

endmodule

// File: tb/tb_craps_table_scheduler.sv
// Directed bench for craps_table_scheduler: turn sequencing, fairness, forfeit,
// score saturation, error flag and reset behaviour with hand-computed expectations.
module tb_craps_table_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       win;
  logic       lose;
  logic [1:0] score_sel;
  logic       roll;
  logic       game_rst;
  logic [3:0] grant;
  logic       turn_done;
  logic [3:0] score;
  logic       err;

  int errors = 0;
  int checks = 0;

  craps_table_scheduler #(.TIMEOUT(200), .SCORE_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .win(win), .lose(lose),
    .score_sel(score_sel), .roll(roll), .game_rst(game_rst), .grant(grant),
    .turn_done(turn_done), .score(score), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; win = 1'b0; lose = 1'b0; score_sel = '0;
    cyc(); cyc();
    #1;
    checks++; if (game_rst !== 1'b1) begin errors++; $display("FAIL rst_game_rst got=%b want=1", game_rst); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b want=0000", grant); end
    checks++; if (roll !== 1'b0) begin errors++; $display("FAIL rst_roll got=%b want=0", roll); end
    checks++; if (turn_done !== 1'b0) begin errors++; $display("FAIL rst_turn_done got=%b want=0", turn_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b want=0", err); end
    for (int i = 0; i < 4; i++) begin
      score_sel = 2'(i);
      #1;
      checks++; if (score !== 4'd0) begin errors++; $display("FAIL rst_score%0d got=%0d want=0", i, score); end
    end
    reset = 1'b0;
    #1;
    checks++; if (game_rst !== 1'b0) begin errors++; $display("FAIL rst_release_game_rst got=%b want=0", game_rst); end
    $display("reset: done");
  endtask

  task automatic test_single_win();
    req = 4'b0001;
    cyc(); #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL win_grant got=%b want=0001", grant); end
    checks++; if (roll !== 1'b1) begin errors++; $display("FAIL win_roll got=%b want=1", roll); end
    cyc(); cyc();
    win = 1'b1;
    cyc();
    win = 1'b0;
    #1;
    checks++; if (roll !== 1'b0) begin errors++; $display("FAIL win_release_roll got=%b want=0", roll); end
    checks++; if (turn_done !== 1'b0) begin errors++; $display("FAIL win_early_done got=%b want=0", turn_done); end
    cyc(); #1;
    score_sel = 2'd0;
    #1;
    checks++; if (turn_done !== 1'b1) begin errors++; $display("FAIL win_turn_done got=%b want=1", turn_done); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL win_settle_grant got=%b want=0000", grant); end
    checks++; if (score !== 4'd1) begin errors++; $display("FAIL win_score0 got=%0d want=1", score); end
    req = 4'b0000;
    cyc(); #1;
    checks++; if (turn_done !== 1'b0) begin errors++; $display("FAIL win_done_pulse got=%b want=0", turn_done); end
    $display("single_win: player0 score=%0d", score);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      checks++; if (grant !== exp_seq[i]) begin errors++; $display("FAIL rr_grant%0d got=%b want=%b", i, grant, exp_seq[i]); end
      $display("round_robin: turn %0d grant=%b", i, grant);
      lose = 1'b1;
      cyc();
      lose = 1'b0;
      cyc();
      if (i == 4) req = 4'b0000;
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      score_sel = 2'(i);
      #1;
      checks++; if (score !== 4'd0) begin errors++; $display("FAIL rr_score%0d got=%0d want=0", i, score); end
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    req = 4'b0100;
    cyc();
    req = 4'b1010;
    #1;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL to_grant got=%b want=0100", grant); end
    checks++; if (roll !== 1'b0) begin errors++; $display("FAIL to_roll_ignored got=%b want=0", roll); end
    for (int k = 1; k <= 200; k++) begin
      #1;
      if (game_rst === 1'b1) pulses++;
      if (k == 200) begin
        checks++; if (game_rst !== 1'b1) begin errors++; $display("FAIL to_pulse_at_200 got=%b want=1", game_rst); end
      end
      cyc();
    end
    #1;
    score_sel = 2'd2;
    #1;
    checks++; if (pulses != 1) begin errors++; $display("FAIL to_pulse_count got=%0d want=1", pulses); end
    checks++; if (turn_done !== 1'b1) begin errors++; $display("FAIL to_turn_done got=%b want=1", turn_done); end
    checks++; if (game_rst !== 1'b0) begin errors++; $display("FAIL to_rst_width got=%b want=0", game_rst); end
    checks++; if (score !== 4'd0) begin errors++; $display("FAIL to_score2 got=%0d want=0", score); end
    cyc();
    cyc(); #1;
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL to_next_grant got=%b want=1000", grant); end
    $display("timeout: forfeit then grant=%b", grant);
    req = 4'b0000; lose = 1'b1;
    cyc();
    lose = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_saturate();
    req = 4'b0010;
    score_sel = 2'd1;
    for (int i = 0; i < 16; i++) begin
      cyc(); #1;
      if (i == 0) begin
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL sat_grant got=%b want=0010", grant); end
      end
      win = 1'b1;
      cyc();
      win = 1'b0;
      cyc();
      if (i == 15) req = 4'b0000;
      cyc(); #1;
      if (i == 14) begin
        checks++; if (score !== 4'd15) begin errors++; $display("FAIL sat_score_15 got=%0d want=15", score); end
      end
    end
    checks++; if (score !== 4'd15) begin errors++; $display("FAIL sat_score_hold got=%0d want=15", score); end
    score_sel = 2'd0;
    #1;
    checks++; if (score !== 4'd0) begin errors++; $display("FAIL sat_other_score got=%0d want=0", score); end
    $display("saturate: player1 held at 15");
  endtask

  task automatic test_err();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_initial got=%b want=0", err); end
    req = 4'b0001;
    cyc();
    win = 1'b1; lose = 1'b1;
    cyc();
    win = 1'b0; lose = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_both got=%b want=1", err); end
    cyc();
    req = 4'b0000;
    cyc(); cyc(); #1;
    score_sel = 2'd0;
    #1;
    checks++; if (score !== 4'd0) begin errors++; $display("FAIL err_no_score got=%0d want=0", score); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", err); end
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b want=0", err); end
    win = 1'b1;
    cyc();
    win = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_idle_win got=%b want=1", err); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL err_idle_grant got=%b want=0000", grant); end
    $display("err: sticky flag exercised");
    do_reset();
  endtask

  task automatic test_reset_mid_turn();
    req = 4'b0010;
    score_sel = 2'd1;
    cyc();
    win = 1'b1;
    cyc();
    win = 1'b0;
    cyc(); cyc();
    #1;
    checks++; if (score !== 4'd1) begin errors++; $display("FAIL mid_prescore got=%0d want=1", score); end
    cyc(); #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL mid_regrant got=%b want=0010", grant); end
    checks++; if (roll !== 1'b1) begin errors++; $display("FAIL mid_roll got=%b want=1", roll); end
    reset = 1'b1;
    #1;
    checks++; if (game_rst !== 1'b1) begin errors++; $display("FAIL mid_game_rst got=%b want=1", game_rst); end
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant got=%b want=0000", grant); end
    checks++; if (roll !== 1'b0) begin errors++; $display("FAIL mid_roll_after got=%b want=0", roll); end
    checks++; if (score !== 4'd0) begin errors++; $display("FAIL mid_score got=%0d want=0", score); end
    checks++; if (turn_done !== 1'b0) begin errors++; $display("FAIL mid_turn_done got=%b want=0", turn_done); end
    $display("reset_mid_turn: turn abandoned");
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_win();
    test_round_robin();
    test_timeout();
    test_saturate();
    test_err();
    test_reset_mid_turn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
